// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared types and encodings for the multi-cycle RV32I controller.
// Includes the FSM state enum, the major opcodes, the ALU operation codes,
// the datapath mux select encodings and the trap cause codes.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_JALR2,
        S_LUIWB,
        S_TRAP
    } state_t;

    // Major opcodes
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Which decode rule the ALU decoder applies
    localparam logic [1:0] ALUC_ADD = 2'd0;
    localparam logic [1:0] ALUC_R   = 2'd1;
    localparam logic [1:0] ALUC_I   = 2'd2;
    localparam logic [1:0] ALUC_BR  = 2'd3;

    // Result mux
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU source muxes
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Trap causes
    localparam logic [1:0] TRAP_NONE    = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [1:0] TRAP_BUS     = 2'b10;

    // Immediate format implied by the opcode
    function automatic logic [2:0] imm_sel(input logic [6:0] opc);
        case (opc)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/riscv_mc_alu_dec.sv
// riscv_mc_alu_dec: combinational ALU decoder. Maps the controller's current
// decode rule (plain add, R-type, I-type, branch compare) plus funct3 and
// funct7[5] onto the 4-bit ALU operation code.
module riscv_mc_alu_dec
    import riscv_mc_pkg::*;
(
    input  logic [1:0] alu_class,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_control
);

    // Operation select; SUB exists only for R-type, SRA for both R and I
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_class)
            ALUC_R, ALUC_I: begin
                case (funct3)
                    3'b000: alu_control = (alu_class == ALUC_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_control = ALU_SLL;
                    3'b010: alu_control = ALU_SLT;
                    3'b011: alu_control = ALU_SLTU;
                    3'b100: alu_control = ALU_XOR;
                    3'b101: alu_control = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110: alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
            ALUC_BR: begin
                case (funct3[2:1])
                    2'b00:   alu_control = ALU_SUB;
                    2'b10:   alu_control = ALU_SLT;
                    2'b11:   alu_control = ALU_SLTU;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control FSM with ready-based memory
// handshake, bus-timeout trap and illegal-opcode trap.
// Optional feature macro: RISCV_MC_PERF_EN enables the cycle/instret counters;
// without it both counter ports are tied to zero.
module riscv_mc_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [2:0]       imm_src,
    output logic             halt,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state_reg, state_next;
    logic [1:0]        trap_cause_reg, trap_cause_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic              in_mem_state;
    logic              wait_expired;
    logic              branch_bad;
    logic              branch_taken;
    logic [1:0]        alu_class;
    logic [3:0]        dec_alu;
    logic              unused_funct7;

    // Only funct7[5] carries meaning for the ALU decode
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    assign in_mem_state = (state_reg == S_FETCH) || (state_reg == S_MEMREAD) ||
                          (state_reg == S_MEMWRITE);
    // Wait counter holds the number of cycles already spent without ready
    assign wait_expired = (wait_cnt_reg == WAIT_W'(MEM_TIMEOUT - 1));
    assign branch_bad   = (funct3[2:1] == 2'b01);
    // SUB/SLT/SLTU leave zero set exactly when BEQ/BGE/BGEU are taken
    assign branch_taken = (zero ^ funct3[0] ^ funct3[2]) & ~branch_bad;

    riscv_mc_alu_dec u_alu_dec (
        .alu_class   (alu_class),
        .funct3      (funct3),
        .funct7_5    (funct7[5]),
        .alu_control (dec_alu)
    );

    // State, trap cause and memory wait counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_FETCH;
            trap_cause_reg <= TRAP_NONE;
            wait_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            trap_cause_reg <= trap_cause_next;
            wait_cnt_reg   <= wait_cnt_next;
        end
    end

    // Next-state logic, trap cause capture and wait counter update
    always_comb begin
        state_next      = state_reg;
        trap_cause_next = trap_cause_reg;
        case (state_reg)
            S_FETCH: begin
                if (mem_ready)         state_next = S_DECODE;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_ITYPE:          state_next = S_EXECI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUIWB;
                    OP_AUIPC:          state_next = S_ALUWB;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (mem_ready)         state_next = S_MEMWB;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_MEMWRITE: begin
                if (mem_ready)         state_next = S_FETCH;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_MEMWB:    state_next = S_FETCH;
            S_EXECR:    state_next = S_ALUWB;
            S_EXECI:    state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = branch_bad ? S_TRAP : S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_JALR:     state_next = S_JALR2;
            S_JALR2:    state_next = S_ALUWB;
            S_LUIWB:    state_next = S_FETCH;
            default:    state_next = S_TRAP;
        endcase

        if (state_next == S_TRAP && state_reg != S_TRAP)
            trap_cause_next = in_mem_state ? TRAP_BUS : TRAP_ILLEGAL;

        // Restarts at zero whenever a memory state is (re)entered
        if (in_mem_state && state_next == state_reg)
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        else
            wait_cnt_next = '0;
    end

    // ALU decode rule selected by the current state
    always_comb begin
        case (state_reg)
            S_EXECR:  alu_class = ALUC_R;
            S_EXECI:  alu_class = ALUC_I;
            S_BRANCH: alu_class = ALUC_BR;
            default:  alu_class = ALUC_ADD;
        endcase
    end

    // Datapath controls per state; everything is forced low while reset is held
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        result_src  = RES_ALUOUT;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_REGB;
        alu_control = ALU_ADD;
        imm_src     = IMM_I;
        halt        = 1'b0;
        if (rst_n) begin
            case (state_reg)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURES;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                    imm_src   = imm_sel(op);
                end
                // Stores need the S-format offset while the address is formed
                S_MEMADR: begin
                    alu_src_a = SRCA_REGA;
                    alu_src_b = SRCB_IMM;
                    imm_src   = imm_sel(op);
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = SRCA_REGA;
                    alu_control = dec_alu;
                end
                S_EXECI: begin
                    alu_src_a   = SRCA_REGA;
                    alu_src_b   = SRCB_IMM;
                    alu_control = dec_alu;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = SRCA_REGA;
                    alu_control = dec_alu;
                    pc_write    = branch_taken;
                end
                S_JAL, S_JALR2: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a = SRCA_REGA;
                    alu_src_b = SRCB_IMM;
                end
                // Immediate travels straight to the register file
                S_LUIWB: begin
                    result_src = RES_IMM;
                    reg_write  = 1'b1;
                    imm_src    = IMM_U;
                end
                S_TRAP: begin
                    halt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign trap_cause = trap_cause_reg;

`ifdef RISCV_MC_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_reg, instret_cnt_reg;
    logic             retire;

    // An instruction retires when a completion state hands back to FETCH
    assign retire = (state_next == S_FETCH) &&
                    ((state_reg == S_MEMWB) || (state_reg == S_MEMWRITE) ||
                     (state_reg == S_ALUWB) || (state_reg == S_BRANCH) ||
                     (state_reg == S_LUIWB));

    // Free-running performance counters, frozen while trapped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_reg   <= '0;
            instret_cnt_reg <= '0;
        end else begin
            if (state_reg != S_TRAP)
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            if (retire)
                instret_cnt_reg <= instret_cnt_reg + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_cnt_reg;
    assign instret_cnt = instret_cnt_reg;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: scoreboard bench for riscv_mc_ctrl. Each instruction pushes
// its expected per-cycle control vectors; the drain loop pops and compares
// one vector per cycle at the falling edge.
module tb_riscv_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  result_src, alu_src_a, alu_src_b;
    logic [3:0]  alu_control;
    logic [2:0]  imm_src;
    logic        halt;
    logic [1:0]  trap_cause;
    logic [31:0] cycle_cnt, instret_cnt;

    riscv_mc_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct3      (funct3),
        .funct7      (funct7),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .adr_src     (adr_src),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .reg_write   (reg_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .imm_src     (imm_src),
        .halt        (halt),
        .trap_cause  (trap_cause),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  result_src, alu_src_a, alu_src_b, alu_control, imm_src, halt, trap_cause};

    typedef struct {
        string       tag;
        bit          rdy;
        logic [21:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [21:0] cv(bit mreq, bit mw, bit adr, bit irw, bit pcw, bit rw,
                                       logic [1:0] rs, logic [1:0] a, logic [1:0] b,
                                       logic [3:0] alu, logic [2:0] imm, bit h, logic [1:0] tc);
        return {mreq, mw, adr, irw, pcw, rw, rs, a, b, alu, imm, h, tc};
    endfunction

    function automatic logic [21:0] f_rdy();  return cv(1,0,0,1,1,0,2'd2,2'd0,2'd2,4'd0,3'd0,0,2'd0); endfunction
    function automatic logic [21:0] f_wait(); return cv(1,0,0,0,0,0,2'd2,2'd0,2'd2,4'd0,3'd0,0,2'd0); endfunction
    function automatic logic [21:0] dec(logic [2:0] imm); return cv(0,0,0,0,0,0,2'd0,2'd1,2'd1,4'd0,imm,0,2'd0); endfunction
    function automatic logic [21:0] aluwb(); return cv(0,0,0,0,0,1,2'd0,2'd0,2'd0,4'd0,3'd0,0,2'd0); endfunction

    task automatic push(input string tag, input bit rdy, input logic [21:0] vec);
        exp_t e;
        e.tag = tag; e.rdy = rdy; e.vec = vec;
        exp_q.push_back(e);
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        op = o; funct3 = f3; funct7 = f7; zero = z;
    endtask

    // Called just after a rising edge; one popped vector per cycle
    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            mem_ready = e.rdy;
            @(negedge clk);
            check(e.tag, {10'd0, obs}, {10'd0, e.vec});
            $display("cycle %-10s obs=%h exp=%h", e.tag, obs, e.vec);
            @(posedge clk);
            #1;
        end
    endtask

    // Reset asserted mid-flight; outputs must drop at once
    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_outs"}, {10'd0, obs}, 32'd0);
        check({tag, "_cyc"}, cycle_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        set_instr(7'h00, 3'd0, 7'd0, 1'b0);
        #12;
        check("rst_outs", {10'd0, obs}, 32'd0);
        check("rst_cycle", cycle_cnt, 32'd0);
        check("rst_instret", instret_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Three back-to-back ADD x3,x1,x2
        set_instr(7'b0110011, 3'b000, 7'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            push("add_f", 1, f_rdy());
            push("add_d", 1, dec(3'd0));
            push("add_ex", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd0,3'd0,0,2'd0));
            push("add_wb", 1, aluwb());
            drain();
        end
`ifdef RISCV_MC_PERF_EN
        check("cyc_3add", cycle_cnt, 32'd12);
        check("ret_3add", instret_cnt, 32'd3);
`else
        check("cyc_off", cycle_cnt, 32'd0);
        check("ret_off", instret_cnt, 32'd0);
`endif

        // SUB
        set_instr(7'b0110011, 3'b000, 7'h20, 1'b0);
        push("sub_f", 1, f_rdy()); push("sub_d", 1, dec(3'd0));
        push("sub_ex", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd1,3'd0,0,2'd0));
        push("sub_wb", 1, aluwb());
        drain();

        // ADDI with funct7[5] set still adds
        set_instr(7'b0010011, 3'b000, 7'h20, 1'b0);
        push("addi_f", 1, f_rdy()); push("addi_d", 1, dec(3'd0));
        push("addi_ex", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd0,0,2'd0));
        push("addi_wb", 1, aluwb());
        drain();

        // SRAI
        set_instr(7'b0010011, 3'b101, 7'h20, 1'b0);
        push("srai_f", 1, f_rdy()); push("srai_d", 1, dec(3'd0));
        push("srai_ex", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd9,3'd0,0,2'd0));
        push("srai_wb", 1, aluwb());
        drain();

        // LW with three wait states in MEMREAD
        set_instr(7'b0000011, 3'b010, 7'h00, 1'b0);
        push("lw_f", 1, f_rdy()); push("lw_d", 1, dec(3'd0));
        push("lw_adr", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd0,0,2'd0));
        for (int i = 0; i < 3; i++) push("lw_wait", 0, cv(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0,2'd0));
        push("lw_rdy", 1, cv(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0,2'd0));
        push("lw_wb", 1, cv(0,0,0,0,0,1,2'd1,2'd0,2'd0,4'd0,3'd0,0,2'd0));
        drain();

        // SW, zero wait states
        set_instr(7'b0100011, 3'b010, 7'h00, 1'b0);
        push("sw_f", 1, f_rdy()); push("sw_d", 1, dec(3'd1));
        push("sw_adr", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd1,0,2'd0));
        push("sw_mem", 1, cv(1,1,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0,2'd0));
        drain();

        // BLT zero=0 taken, BGE zero=0 not taken, BEQ zero=1 taken
        set_instr(7'b1100011, 3'b100, 7'h00, 1'b0);
        push("blt_f", 1, f_rdy()); push("blt_d", 1, dec(3'd2));
        push("blt_br", 1, cv(0,0,0,0,1,0,2'd0,2'd2,2'd0,4'd5,3'd0,0,2'd0));
        drain();
        set_instr(7'b1100011, 3'b101, 7'h00, 1'b0);
        push("bge_f", 1, f_rdy()); push("bge_d", 1, dec(3'd2));
        push("bge_br", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd5,3'd0,0,2'd0));
        drain();
        set_instr(7'b1100011, 3'b000, 7'h00, 1'b1);
        push("beq_f", 1, f_rdy()); push("beq_d", 1, dec(3'd2));
        push("beq_br", 1, cv(0,0,0,0,1,0,2'd0,2'd2,2'd0,4'd1,3'd0,0,2'd0));
        drain();

        // JALR: five cycles
        set_instr(7'b1100111, 3'b000, 7'h00, 1'b0);
        push("jalr_f", 1, f_rdy()); push("jalr_d", 1, dec(3'd0));
        push("jalr_1", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd0,0,2'd0));
        push("jalr_2", 1, cv(0,0,0,0,1,0,2'd0,2'd1,2'd2,4'd0,3'd0,0,2'd0));
        push("jalr_wb", 1, aluwb());
        drain();

        // LUI
        set_instr(7'b0110111, 3'b000, 7'h00, 1'b0);
        push("lui_f", 1, f_rdy()); push("lui_d", 1, dec(3'd4));
        push("lui_wb", 1, cv(0,0,0,0,0,1,2'd3,2'd0,2'd0,4'd0,3'd4,0,2'd0));
        drain();

        // Reset during a stalled load access
        set_instr(7'b0000011, 3'b010, 7'h00, 1'b0);
        push("lwr_f", 1, f_rdy()); push("lwr_d", 1, dec(3'd0));
        push("lwr_adr", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd1,4'd0,3'd0,0,2'd0));
        push("lwr_wait", 0, cv(1,0,1,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,0,2'd0));
        drain();
        pulse_reset("rst_mem");

        // Fetch never acknowledged: bus timeout after four cycles
        set_instr(7'b0110011, 3'b000, 7'h00, 1'b0);
        for (int i = 0; i < 4; i++) push("to_wait", 0, f_wait());
        push("to_trap", 0, cv(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1,2'd2));
        push("to_trap2", 1, cv(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1,2'd2));
        drain();
        pulse_reset("rst_to");

        // Illegal opcode traps from DECODE
        set_instr(7'h7F, 3'b000, 7'h00, 1'b0);
        push("ill_f", 1, f_rdy()); push("ill_d", 1, dec(3'd0));
        push("ill_trap", 1, cv(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1,2'd1));
        push("ill_trap2", 1, cv(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1,2'd1));
        drain();
        pulse_reset("rst_ill");

        // Branch with reserved funct3 traps as illegal, no pc_write
        set_instr(7'b1100011, 3'b010, 7'h00, 1'b1);
        push("bbad_f", 1, f_rdy()); push("bbad_d", 1, dec(3'd2));
        push("bbad_br", 1, cv(0,0,0,0,0,0,2'd0,2'd2,2'd0,4'd0,3'd0,0,2'd0));
        push("bbad_trap", 1, cv(0,0,0,0,0,0,2'd0,2'd0,2'd0,4'd0,3'd0,1,2'd1));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
